// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with registered-read or FWFT read path, programmable almost flags and sticky errors.
// Read latency 1 edge (FWFT=0) or 0 (FWFT=1); writes at full are rejected unless a read pops the same cycle; optional peak tracker under SYNC_FIFO_PROG_WATERMARK_EN.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = $clog2(DEPTH),
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_BITS:0]    af_thresh,
  input  logic [ADDR_BITS:0]    ae_thresh,
  input  logic                  err_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky,
  output logic [ADDR_BITS:0]    count
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
  ,
  output logic [ADDR_BITS:0]    watermark
`endif
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_rej;
  logic                  rd_rej;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  assign rd_acc = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign wr_acc = wr_en && (!full || rd_acc);
  assign wr_rej = wr_en && !wr_acc;
  assign rd_rej = rd_en && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_BITS'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_BITS+1)'(1);
        2'b01:   count <= count - (ADDR_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; contents are dropped via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      overflow   <= wr_rej;
      underflow  <= rd_rej;
      ovf_sticky <= wr_rej || (ovf_sticky && !err_clr);
      udf_sticky <= rd_rej || (udf_sticky && !err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg_read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) rd_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

`ifdef SYNC_FIFO_PROG_WATERMARK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      watermark <= '0;
    end else if (err_clr || (count > watermark)) begin
      watermark <= count;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: a registered-read and an FWFT instance driven by the same stimulus.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [4:0] af_thresh = 5'd14;
  logic [4:0] ae_thresh = 5'd2;
  logic       err_clr = 1'b0;

  logic [7:0] rd_data, f_rd_data;
  logic       rd_valid, f_rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic       overflow, underflow, ovf_sticky, udf_sticky;
  logic [4:0] count;
  logic       f_full, f_empty, f_almost_full, f_almost_empty;
  logic       f_overflow, f_underflow, f_ovf_sticky, f_udf_sticky;
  logic [4:0] f_count;
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
  logic [4:0] watermark, f_watermark;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .count(count)
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
    , .watermark(watermark)
`endif
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .err_clr(err_clr), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .overflow(f_overflow), .underflow(f_underflow),
    .ovf_sticky(f_ovf_sticky), .udf_sticky(f_udf_sticky), .count(f_count)
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
    , .watermark(f_watermark)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [$];

    // Reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'({overflow, underflow, ovf_sticky, udf_sticky}), 0);
    chk("rst_rd", 32'({rd_valid, rd_data}), 0);
    chk("rst_f_valid", 32'(f_rd_valid), 0);
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
    chk("rst_wm", 32'(watermark), 0);
`endif
    rst_n = 1'b1;
    tick();

    // FWFT: single word falls through without rd_en
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    chk("fwft_valid", 32'(f_rd_valid), 1);
    chk("fwft_data", 32'(f_rd_data), 32'h55);
    chk("reg_no_valid", 32'(rd_valid), 0);
    chk("wr_count", 32'(count), 1);
    chk("wr_not_empty", 32'(empty), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 1);
    chk("fwft_pop_valid", 32'(f_rd_valid), 0);
    chk("reg_rd_valid", 32'(rd_valid), 1);
    chk("reg_rd_data", 32'(rd_data), 32'h55);
    tick();
    chk("reg_valid_pulse", 32'(rd_valid), 0);
    chk("reg_data_hold", 32'(rd_data), 32'h55);

    // Fill to full with 0x00..0x0F, probing threshold edges
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      if (i == 1)  chk("ae_at2", 32'(almost_empty), 1);
      if (i == 2)  chk("ae_at3", 32'(almost_empty), 0);
      if (i == 12) chk("af_at13", 32'(almost_full), 0);
      if (i == 13) chk("af_at14", 32'(almost_full), 1);
      if (i == 14) chk("full_at15", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_no_ovf", 32'(overflow), 0);

    // Rejected 17th write
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_sticky", 32'(ovf_sticky), 1);
    chk("ovf_count", 32'(count), 16);
    tick();
    chk("ovf_one_cycle", 32'(overflow), 0);
    chk("ovf_sticky_hold", 32'(ovf_sticky), 1);

    // Simultaneous read+write at full
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_full_no_ovf", 32'(overflow), 0);
    chk("rw_full_count", 32'(count), 16);
    chk("rw_full_rd", 32'({rd_valid, rd_data}), 32'h100);
    chk("rw_full_f_count", 32'(f_count), 16);

    // Drain: 0x01..0x0F then 0xAA
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fwft_head%0d", i), 32'(f_rd_data), 32'(exp_q[i]));
      rd_en = 1'b1;
      tick();
      chk($sformatf("drain%0d", i), 32'({rd_valid, rd_data}), 32'({1'b1, exp_q[i]}));
    end
    rd_en = 1'b0;
    tick();
    chk("drain_valid_low", 32'(rd_valid), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_no_udf", 32'(underflow), 0);

    // Underflow and sticky clear priority
    rd_en = 1'b1;
    tick();
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_sticky", 32'(udf_sticky), 1);
    chk("udf_count", 32'(count), 0);
    err_clr = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_set_wins", 32'(udf_sticky), 1);
    tick();
    err_clr = 1'b0;
    chk("udf_cleared", 32'(udf_sticky), 0);
    chk("ovf_cleared", 32'(ovf_sticky), 0);
    chk("udf_pulse_end", 32'(underflow), 0);

    // Read+write on empty: write lands, read underflows
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_empty_count", 32'(count), 1);
    chk("rw_empty_udf", 32'(underflow), 1);
    chk("rw_empty_no_rd", 32'(rd_valid), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rw_empty_data", 32'(rd_data), 32'h3C);

    // Programmable thresholds
    af_thresh = 5'd12; ae_thresh = 5'd3;
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      tick();
      if (i == 10) chk("af12_at11", 32'(almost_full), 0);
    end
    wr_en = 1'b0;
    chk("af12_at12", 32'(almost_full), 1);
    af_thresh = 5'd13;
    #1;
    chk("af13_live", 32'(almost_full), 0);
    rd_en = 1'b1;
    tick(); tick(); tick();
    rd_en = 1'b0;
    chk("pop3_count", 32'(count), 9);
    chk("ae3_at9", 32'(almost_empty), 0);
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
    chk("wm_peak", 32'(watermark), 12);
`endif

    // Asynchronous reset mid-fill
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_af", 32'(almost_full), 0);
`ifdef SYNC_FIFO_PROG_WATERMARK_EN
    chk("arst_wm", 32'(watermark), 0);
`endif
    af_thresh = 5'd0;
    #1;
    chk("arst_af_zero", 32'(almost_full), 1);
    af_thresh = 5'd12;
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'hC3;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_rst_data", 32'(rd_data), 32'hC3);
    chk("post_rst_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
